// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin front end sharing one GCD engine between two requesters
// Latches one operand pair at a time, drives the engine start/done protocol, and routes the result to its owner.
module gcd_scheduler #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_gcd,
    output logic             resp0_err,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_gcd,
    output logic             resp1_err,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_gcd,
    output logic             busy
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] eng_a_q, eng_a_d;
    logic [WIDTH-1:0] eng_b_q, eng_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic             idle;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign idle   = (state_q == S_IDLE);
    assign grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
    assign grant1 = req1_valid && (!req0_valid || rr_ptr_q);
    // Gated by rst_n so ready is also low while reset is held.
    assign req0_ready = rst_n && idle && grant0;
    assign req1_ready = rst_n && idle && grant1;
    assign accept     = req0_ready || req1_ready;
    assign sel_a      = req1_ready ? req1_a : req0_a;
    assign sel_b      = req1_ready ? req1_b : req0_b;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        eng_a_d  = eng_a_q;
        eng_b_d  = eng_b_q;
        result_d = result_q;
        err_d    = err_q;
        wd_d     = wd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d  = req1_ready;
                    rr_ptr_d = !req1_ready;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_ISSUE;
                        eng_a_d = sel_a;
                        eng_b_d = sel_b;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final watchdog cycle still wins over the timeout.
                if (eng_done) begin
                    result_d = eng_gcd;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ZERO: begin
                result_d = a_q | b_q;
                err_d    = 1'b0;
                state_d  = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            eng_a_q  <= eng_a_d;
            eng_b_q  <= eng_b_d;
            result_q <= result_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign eng_start   = (state_q == S_ISSUE);
    assign eng_a       = eng_a_q;
    assign eng_b       = eng_b_q;
    assign busy        = !idle;
    assign resp0_valid = (state_q == S_RESP) && !owner_q;
    assign resp1_valid = (state_q == S_RESP) && owner_q;
    assign resp0_gcd   = resp0_valid ? result_q : '0;
    assign resp1_gcd   = resp1_valid ? result_q : '0;
    assign resp0_err   = resp0_valid && err_q;
    assign resp1_err   = resp1_valid && err_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - directed and randomized checks of gcd_scheduler against a behavioural model
module tb_gcd_scheduler;
    localparam int W  = 16;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [W-1:0] resp0_gcd, resp1_gcd;
    logic         eng_start, busy;
    logic [W-1:0] eng_a, eng_b;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_gcd = '0;

    gcd_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_gcd(resp0_gcd), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_gcd(resp1_gcd), .resp1_err(resp1_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_gcd(eng_gcd), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int resp_pulses = 0;
    int rr_model = 0;
    logic [W-1:0] last_a = '0, last_b = '0;

    // Engine model: done arrives eng_delay cycles into WAIT, or never when eng_hang is set.
    int eng_delay = 1;
    bit eng_hang = 1'b0;
    int stray_set = 0;
    int stray_seen = 0;
    int eng_cnt = 0;
    int starts = 0;
    logic [W-1:0] cap_a = '0, cap_b = '0, eng_res = '0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (stray_set != stray_seen) begin
                stray_seen = stray_set;
                eng_done   = 1'b1;
                eng_gcd    = 16'h5a5a;
            end
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_gcd  = eng_res;
                end
            end
            if (eng_start) begin
                starts  = starts + 1;
                cap_a   = eng_a;
                cap_b   = eng_b;
                eng_res = ref_gcd(eng_a, eng_b);
                eng_cnt = eng_hang ? 0 : eng_delay;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        check("ready_exclusive", 32'(req0_ready & req1_ready), 0);
        check("ready_while_busy", 32'(busy & (req0_ready | req1_ready)), 0);
        if (resp0_valid || resp1_valid) resp_pulses++;
    endtask

    task automatic drive(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
    endtask

    task automatic wait_accept(input int who, input bit keep, output int n);
        n = 0;
        while (!((who == 0) ? req0_ready : req1_ready) && n < 200) begin
            tick();
            n++;
        end
        check("accept_in_budget", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
    endtask

    task automatic finish_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int delay, input bit hang, input string tag);
        bit zero, seen;
        logic [W-1:0] eg;
        logic eerr;
        int lat, k, s0, p0;
        zero = (a == 0) || (b == 0);
        eerr = hang && !zero;
        eg   = eerr ? '0 : ref_gcd(a, b);
        lat  = zero ? 2 : (hang ? 2 + TO : 2 + delay);
        s0 = starts;
        p0 = resp_pulses;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin
            tick();
            k++;
            seen = (who == 0) ? resp0_valid : resp1_valid;
        end
        check({tag, "_latency"}, k, lat);
        check({tag, "_gcd"}, 32'((who == 0) ? resp0_gcd : resp1_gcd), 32'(eg));
        check({tag, "_err"}, 32'((who == 0) ? resp0_err : resp1_err), 32'(eerr));
        check({tag, "_other_quiet"}, 32'((who == 0) ? resp1_valid : resp0_valid), 0);
        tick();
        check({tag, "_one_cycle"}, 32'(resp0_valid | resp1_valid), 0);
        check({tag, "_pulses"}, resp_pulses - p0, 1);
        check({tag, "_starts"}, starts - s0, zero ? 0 : 1);
        if (!zero) begin
            check({tag, "_eng_a"}, 32'(cap_a), 32'(a));
            check({tag, "_eng_b"}, 32'(cap_b), 32'(b));
            last_a = a;
            last_b = b;
        end else begin
            check({tag, "_eng_a_held"}, 32'(eng_a), 32'(last_a));
            check({tag, "_eng_b_held"}, 32'(eng_b), 32'(last_b));
        end
    endtask

    task automatic do_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int delay, input bit hang, input string tag);
        int n;
        eng_delay = delay;
        eng_hang  = hang;
        @(negedge clk);
        drive(who, a, b);
        #1;
        wait_accept(who, 1'b0, n);
        rr_model = 1 - who;
        finish_op(who, a, b, delay, hang, tag);
    endtask

    task automatic do_pair(input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int delay, input string tag);
        int first, n;
        first = rr_model;
        eng_delay = delay;
        eng_hang  = 1'b0;
        @(negedge clk);
        drive(0, a0, b0);
        drive(1, a1, b1);
        #1;
        wait_accept(first, 1'b0, n);
        rr_model = 1 - first;
        finish_op(first, first == 0 ? a0 : a1, first == 0 ? b0 : b1, delay, 1'b0, {tag, "_first"});
        wait_accept(1 - first, 1'b0, n);
        check({tag, "_second_immediate"}, n, 0);
        rr_model = first;
        finish_op(1 - first, first == 0 ? a1 : a0, first == 0 ? b1 : b0, delay, 1'b0, {tag, "_second"});
    endtask

    initial begin
        int n, p0, who, dly;
        logic [W-1:0] ra, rb, ra2, rb2;

        req0_valid = 1'b1;
        repeat (3) tick();
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_eng_a", 32'(eng_a), 0);
        check("rst_eng_b", 32'(eng_b), 0);
        check("rst_resp", 32'({resp0_valid, resp1_valid, resp0_err, resp1_err}), 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_pair(5, 2, 12, 18, 2, "pair_a");
        check("pair_a_rr", rr_model, 0);
        do_op(0, 9, 3, 5, 1'b0, "single");
        do_pair(7, 21, 30, 45, 1, "pair_b");

        do_op(1, 0, 7, 1, 1'b0, "zero_a");
        do_op(1, 0, 0, 1, 1'b0, "zero_both");
        do_op(0, 40, 7, 1, 1'b1, "timeout");
        do_op(0, 8, 12, 3, 1'b0, "after_timeout");

        // Back-to-back: requester 0 keeps valid high across two operations.
        eng_delay = 1;
        eng_hang  = 1'b0;
        @(negedge clk);
        drive(0, 9, 3);
        #1;
        wait_accept(0, 1'b1, n);
        req0_a = 5;
        req0_b = 2;
        finish_op(0, 9, 3, 1, 1'b0, "b2b_1");
        wait_accept(0, 1'b0, n);
        check("b2b_immediate_accept", n, 0);
        finish_op(0, 5, 2, 1, 1'b0, "b2b_2");
        rr_model = 1;

        // Reset while waiting on a hung engine.
        eng_hang = 1'b1;
        @(negedge clk);
        drive(1, 21, 14);
        #1;
        wait_accept(1, 1'b0, n);
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy), 1);
        p0 = resp_pulses;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_eng_start", 32'(eng_start), 0);
        check("mid_rst_eng_a", 32'(eng_a), 0);
        check("mid_rst_eng_b", 32'(eng_b), 0);
        check("mid_rst_resp", 32'({resp0_valid, resp1_valid}), 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        rr_model = 0;
        last_a = '0;
        last_b = '0;
        stray_set++;
        repeat (3) tick();
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_no_resp", resp_pulses - p0, 0);
        do_op(0, 9, 6, 2, 1'b0, "after_rst");

        for (int i = 0; i < 16; i++) begin
            who = int'($urandom_range(0, 1));
            ra  = W'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 2000));
            rb  = W'($urandom_range(1, 60) * $urandom_range(1, 30));
            dly = int'($urandom_range(1, 6));
            do_op(who, ra, rb, dly, $urandom_range(0, 9) == 0, "rand_op");
        end
        for (int i = 0; i < 3; i++) begin
            ra  = W'($urandom_range(1, 500));
            rb  = W'($urandom_range(1, 500));
            ra2 = W'($urandom_range(1, 500));
            rb2 = W'($urandom_range(1, 500));
            do_pair(ra, rb, ra2, rb2, int'($urandom_range(1, 4)), "rand_pair");
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
- Round-robin scheduler that shares one Greatest_Common_Divisor engine between two requesters.
- Accepts operand pairs over a valid/ready handshake and sequences the engine's start/done protocol.
- Routes each result back to the requester that issued it.
- Bypasses the engine for zero operands and recovers from a hung engine with a watchdog timeout.

Parameters:
- WIDTH, 16: operand and result width.
- TIMEOUT, 1024: maximum cycles to wait for eng_done after eng_start before aborting (must be at least 2).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- resp0_valid  out  1  one-cycle pulse: result for requester 0.
- resp0_gcd  out  WIDTH  result for requester 0, valid with resp0_valid.
- resp0_err  out  1  timeout flag, valid with resp0_valid.
- req1_valid, req1_a, req1_b, req1_ready, resp1_valid, resp1_gcd, resp1_err: same as requester 0, for requester 1.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  WIDTH  operand a to the engine, held from issue until done.
- eng_b  out  WIDTH  operand b to the engine, held from issue until done.
- eng_done  in  1  engine completion pulse.
- eng_gcd  in  WIDTH  engine result, valid with eng_done.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - All outputs 0: ready, resp, err, eng_start, eng_a, eng_b, busy.
  - Watchdog counter cleared.
- Ready: req0_ready and req1_ready are combinational, asserted only in IDLE, and only toward the grant winner. Never both in the same cycle.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester selected by rr_ptr wins.
  - rr_ptr toggles to the non-winner on every accept.
  - Accept is valid&ready at a posedge. Operands and owner id are latched at that edge.
- States:
  - IDLE -> ZERO if either latched operand is 0; otherwise IDLE -> ISSUE.
  - ISSUE: eng_start=1 for exactly this one cycle, with eng_a/eng_b = latched operands. ISSUE -> WAIT.
  - WAIT: watchdog increments each cycle.
    - eng_done=1: capture eng_gcd, err=0, go to RESP.
    - Watchdog reaches TIMEOUT-1 with no done: result=0, err=1, go to RESP.
  - ZERO: result = a|b, so gcd(x,0)=x and gcd(0,0)=0. err=0. Engine untouched. ZERO -> RESP.
  - RESP: respN_valid=1 for one cycle for the owner, with respN_gcd/respN_err. Other requester's resp stays 0. RESP -> IDLE.
- Latency:
  - Engine path: accept at edge N, eng_start high in cycle N+1.
  - eng_done in cycle M gives resp_valid in cycle M+1.
  - Minimum accept-to-resp = 3 cycles when done arrives in the first WAIT cycle.
  - Zero bypass: resp_valid in cycle N+2.
- eng_done outside WAIT is ignored; no state change and no response.
- eng_a/eng_b hold their values until the next ISSUE.
- Back-to-back: next accept is possible in the cycle after RESP (IDLE). Throughput is one operation in flight.
- Requesters hold valid and operands until ready. The scheduler never drops an accepted request.
- Reset mid-operation aborts immediately to IDLE. No response is produced for the in-flight request, and eng_start deasserts at once.
- Width: no arithmetic beyond OR and the watchdog compare. The watchdog is clog2(TIMEOUT) bits and saturates-free because it is cleared on entry to WAIT.

Test Plan:
- Single request: req0 a=9, b=3; engine model returns 3 after 5 cycles -> eng_start pulses once with 9/3; resp0_valid one cycle with gcd=3, err=0; resp1_valid stays 0.
- Simultaneous: req0 (5,2) and req1 (12,18) valid in the same cycle after reset -> req0 served first (gcd 1), then req1 (gcd 6). Next simultaneous pair: req1 served first.
- Zero bypass: req1 a=0, b=7 -> resp1 gcd=7 two cycles after accept, eng_start never asserted. Then (0,0) -> gcd=0.
- Timeout: engine never raises done, TIMEOUT=16 -> resp0_valid with err=1, gcd=0 after 16 WAIT cycles. A following (8,12) completes normally with gcd=4.
- Reset mid-operation: rst_n low during WAIT -> outputs 0 asynchronously, no resp pulse. After release, a new request completes correctly and a stray eng_done in IDLE is ignored.
- Back-to-back: req0 held valid with (9,3) then (5,2) -> two accepts, results 3 then 1, each resp exactly one cycle, ready low while busy.
